// File: rtl/mac_vec_feeder_if.sv
// Result handshake between mac_vec_feeder (master) and its consumer (slave).
// Carries the captured 2N-bit dot product and its valid/ready pair.
interface mac_vec_feeder_if #(
    parameter int N = 32
);
    logic [2*N-1:0] res;
    logic           res_valid;
    logic           res_ready;

    modport master (
        output res,
        output res_valid,
        input  res_ready
    );

    modport slave (
        input  res,
        input  res_valid,
        output res_ready
    );
endinterface

// File: rtl/mac_vec_feeder.sv
// Operand sequencer for one mac_1x1: buffers two vectors, clears, streams, and captures the dot product.
// Optional length checking with a len_err pulse is enabled by defining MAC_VEC_FEEDER_LEN_ERR_EN.
module mac_vec_feeder #(
    parameter int N       = 32,
    parameter int ADDR_W  = 4,
    parameter int MAC_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [N-1:0]      wr_a,
    input  logic [N-1:0]      wr_b,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              mac_clr,
    output logic [N-1:0]      mac_a,
    output logic [N-1:0]      mac_b,
    input  logic [2*N-1:0]    mac_res,
`ifdef MAC_VEC_FEEDER_LEN_ERR_EN
    output logic              len_err,
`endif
    mac_vec_feeder_if.master  res_if
);
    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_L   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [2:0]        WAIT_LAST = 3'(MAC_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_FEED,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t state, state_nxt;

    logic [N-1:0]      buf_a [DEPTH];
    logic [N-1:0]      buf_b [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nxt;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   len_eff;
    logic [2:0]        wait_cnt;
    logic              len_ok;
    logic              accept;
    logic              last_elem;
    logic              wait_done;

    assign busy      = (state != ST_IDLE);
    assign idx_nxt   = idx + ADDR_W'(1);
    assign last_elem = ({1'b0, idx} == (len_q - (ADDR_W+1)'(1)));
    assign wait_done = (wait_cnt == WAIT_LAST);
    assign accept    = start && len_ok;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        len_eff = len;
`ifdef MAC_VEC_FEEDER_LEN_ERR_EN
        len_ok = (len != '0) && (len <= DEPTH_L);
`else
        len_ok = (len != '0);
        if (len > DEPTH_L) len_eff = DEPTH_L;
`endif
    end

    // NOTE: operand buffers are plain storage with no reset, so contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            buf_a[wr_addr] <= wr_a;
            buf_b[wr_addr] <= wr_b;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)        state_nxt = ST_CLR;
            ST_CLR:                     state_nxt = ST_FEED;
            ST_FEED: if (last_elem)     state_nxt = ST_WAIT;
            ST_WAIT: if (wait_done)     state_nxt = ST_DONE;
            ST_DONE: if (res_if.res_ready) state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    // MAC-facing outputs are registered: each edge loads the value for the coming cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mac_clr          <= 1'b0;
            mac_a            <= '0;
            mac_b            <= '0;
            res_if.res       <= '0;
            res_if.res_valid <= 1'b0;
            idx              <= '0;
            wait_cnt         <= '0;
            len_q            <= '0;
        end else begin
            mac_clr <= 1'b0;
            mac_a   <= '0;
            mac_b   <= '0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mac_clr <= 1'b1;
                        len_q   <= len_eff;
                    end
                end
                ST_CLR: begin
                    idx   <= '0;
                    mac_a <= buf_a[0];
                    mac_b <= buf_b[0];
                end
                ST_FEED: begin
                    if (last_elem) begin
                        wait_cnt <= '0;
                    end else begin
                        idx   <= idx_nxt;
                        mac_a <= buf_a[idx_nxt];
                        mac_b <= buf_b[idx_nxt];
                    end
                end
                ST_WAIT: begin
                    if (wait_done) begin
                        res_if.res       <= mac_res;
                        res_if.res_valid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                ST_DONE: begin
                    if (res_if.res_ready) res_if.res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef MAC_VEC_FEEDER_LEN_ERR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) len_err <= 1'b0;
        else      len_err <= (state == ST_IDLE) && start && !len_ok;
    end
`endif

endmodule

// File: tb/tb_mac_vec_feeder.sv
// Directed bench for mac_vec_feeder with a behavioural mac_1x1 accumulator.
// Length-bound expectations follow MAC_VEC_FEEDER_LEN_ERR_EN.
module tb_mac_vec_feeder;
    localparam int N = 32;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [N-1:0]      wr_a = '0;
    logic [N-1:0]      wr_b = '0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   len = '0;
    logic              busy;
    logic              mac_clr;
    logic [N-1:0]      mac_a;
    logic [N-1:0]      mac_b;
    logic [2*N-1:0]    acc = '0;
`ifdef MAC_VEC_FEEDER_LEN_ERR_EN
    logic              len_err;
`endif

    int pass_cnt = 0;
    int chk_cnt  = 0;

    mac_vec_feeder_if #(.N(N)) rif ();

    mac_vec_feeder #(.N(N), .ADDR_W(ADDR_W), .MAC_LAT(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_a    (wr_a),
        .wr_b    (wr_b),
        .start   (start),
        .len     (len),
        .busy    (busy),
        .mac_clr (mac_clr),
        .mac_a   (mac_a),
        .mac_b   (mac_b),
        .mac_res (acc),
`ifdef MAC_VEC_FEEDER_LEN_ERR_EN
        .len_err (len_err),
`endif
        .res_if  (rif)
    );

    always #5 clk = ~clk;

    // mac_1x1 stand-in: out_mac is the accumulator register itself.
    always @(posedge clk) begin
        if (mac_clr) acc <= '0;
        else         acc <= acc + mac_a * mac_b;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [ADDR_W-1:0] a, input logic [N-1:0] va, input logic [N-1:0] vb);
        wr_en = 1'b1; wr_addr = a; wr_a = va; wr_b = vb;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start(input int l);
        start = 1'b1; len = (ADDR_W+1)'(l);
        tick();
        start = 1'b0;
    endtask

    // Counts edges until res_valid, continuing from n; gives up after the budget.
    task automatic wait_valid(inout int n);
        while (!rif.res_valid && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic accept_result();
        rif.res_ready = 1'b1;
        tick();
        rif.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        chk_cnt++;
        if ({busy, mac_clr, mac_a, mac_b, rif.res, rif.res_valid} !== '0)
            $display("FAIL reset_outputs: busy=%0b clr=%0b a=%0h b=%0h res=%0h valid=%0b, want all 0",
                     busy, mac_clr, mac_a, mac_b, rif.res, rif.res_valid);
        else pass_cnt++;
`ifdef MAC_VEC_FEEDER_LEN_ERR_EN
        chk_cnt++;
        if (len_err !== 1'b0) $display("FAIL reset_len_err: got %0b want 0", len_err);
        else pass_cnt++;
`endif
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [N-1:0] exp_a [3];
        exp_a[0] = 9; exp_a[1] = 1; exp_a[2] = 3;
        write_entry(0, 9, 2);
        write_entry(1, 1, 4);
        write_entry(2, 3, 5);
        pulse_start(3);
        chk_cnt++;
        if ({mac_clr, busy} !== 2'b11) $display("FAIL basic_clr: clr,busy=%b want 11", {mac_clr, busy});
        else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_cnt++;
            if (mac_a !== exp_a[k] || mac_clr !== 1'b0)
                $display("FAIL basic_feed%0d: mac_a=%0d clr=%0b want %0d,0", k, mac_a, mac_clr, exp_a[k]);
            else pass_cnt++;
        end
        tick();
        chk_cnt++;
        if (mac_a !== '0 || rif.res_valid !== 1'b0)
            $display("FAIL basic_wait: mac_a=%0d valid=%0b want 0,0", mac_a, rif.res_valid);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (rif.res_valid !== 1'b1 || rif.res !== 64'd37)
            $display("FAIL basic_result: valid=%0b res=%0d want 1,37", rif.res_valid, rif.res);
        else pass_cnt++;
        for (int h = 0; h < 4; h++) begin
            tick();
            chk_cnt++;
            if (rif.res_valid !== 1'b1 || busy !== 1'b1)
                $display("FAIL basic_hold%0d: valid=%0b busy=%0b want 1,1", h, rif.res_valid, busy);
            else pass_cnt++;
        end
        accept_result();
        chk_cnt++;
        if (rif.res_valid !== 1'b0 || busy !== 1'b0 || rif.res !== 64'd37)
            $display("FAIL basic_accept: valid=%0b busy=%0b res=%0d want 0,0,37", rif.res_valid, busy, rif.res);
        else pass_cnt++;
    endtask

    task automatic test_busy_protect();
        int n;
        pulse_start(3);
        tick();
        start = 1'b1; len = 1;
        wr_en = 1'b1; wr_addr = 0; wr_a = 7; wr_b = 7;
        tick();
        start = 1'b0; wr_en = 1'b0;
        chk_cnt++;
        if (busy !== 1'b1 || mac_a !== 32'd1)
            $display("FAIL busy_midfeed: busy=%0b mac_a=%0d want 1,1", busy, mac_a);
        else pass_cnt++;
        n = 2;
        wait_valid(n);
        chk_cnt++;
        if (n !== 5 || rif.res !== 64'd37)
            $display("FAIL busy_run1: latency=%0d res=%0d want 5,37", n, rif.res);
        else pass_cnt++;
        accept_result();
        tick();
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL busy_no_queue: busy=%0b want 0", busy);
        else pass_cnt++;
        pulse_start(3);
        n = 0;
        wait_valid(n);
        chk_cnt++;
        if (n !== 5 || rif.res !== 64'd37)
            $display("FAIL busy_run2: latency=%0d res=%0d want 5,37", n, rif.res);
        else pass_cnt++;
        accept_result();
    endtask

    task automatic test_reset_mid_run();
        int n;
        pulse_start(3);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_cnt++;
        if ({busy, mac_clr, mac_a, mac_b, rif.res, rif.res_valid} !== '0)
            $display("FAIL midreset_outputs: busy=%0b clr=%0b a=%0h b=%0h res=%0h valid=%0b, want all 0",
                     busy, mac_clr, mac_a, mac_b, rif.res, rif.res_valid);
        else pass_cnt++;
        tick();
        rst = 1'b1;
        tick();
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL midreset_idle: busy=%0b want 0", busy);
        else pass_cnt++;
        pulse_start(3);
        n = 0;
        wait_valid(n);
        chk_cnt++;
        if (n !== 5 || rif.res !== 64'd37)
            $display("FAIL midreset_rerun: latency=%0d res=%0d want 5,37", n, rif.res);
        else pass_cnt++;
        accept_result();
    endtask

    task automatic test_single();
        int n;
        write_entry(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rif.res_ready = 1'b1;
        pulse_start(1);
        n = 0;
        wait_valid(n);
        chk_cnt++;
        if (n !== 3 || rif.res !== 64'hFFFF_FFFE_0000_0001)
            $display("FAIL single_result: latency=%0d res=%0h want 3,fffffffe00000001", n, rif.res);
        else pass_cnt++;
        tick();
        rif.res_ready = 1'b0;
        chk_cnt++;
        if (rif.res_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL single_early_ready: valid=%0b busy=%0b want 0,0", rif.res_valid, busy);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int n;
        for (int i = 0; i < 16; i++) write_entry(ADDR_W'(i), 1, 1);
        pulse_start(16);
        n = 0;
        wait_valid(n);
        chk_cnt++;
        if (n !== 18 || rif.res !== 64'd16)
            $display("FAIL full_run1: latency=%0d res=%0d want 18,16", n, rif.res);
        else pass_cnt++;
        accept_result();
        chk_cnt++;
        if (rif.res_valid !== 1'b0) $display("FAIL full_accept: valid=%0b want 0", rif.res_valid);
        else pass_cnt++;
        pulse_start(16);
        n = 0;
        wait_valid(n);
        chk_cnt++;
        if (n !== 18 || rif.res !== 64'd16)
            $display("FAIL full_run2: latency=%0d res=%0d want 18,16", n, rif.res);
        else pass_cnt++;
        accept_result();
    endtask

    task automatic test_len_bounds();
`ifdef MAC_VEC_FEEDER_LEN_ERR_EN
        int bad [2];
        bad[0] = 0; bad[1] = 17;
        for (int i = 0; i < 2; i++) begin
            pulse_start(bad[i]);
            chk_cnt++;
            if (len_err !== 1'b1 || busy !== 1'b0)
                $display("FAIL len_err_pulse%0d: len_err=%0b busy=%0b want 1,0", bad[i], len_err, busy);
            else pass_cnt++;
            tick();
            chk_cnt++;
            if (len_err !== 1'b0 || busy !== 1'b0)
                $display("FAIL len_err_drop%0d: len_err=%0b busy=%0b want 0,0", bad[i], len_err, busy);
            else pass_cnt++;
        end
`else
        int n;
        pulse_start(0);
        tick();
        chk_cnt++;
        if (busy !== 1'b0 || mac_clr !== 1'b0)
            $display("FAIL len0_ignored: busy=%0b clr=%0b want 0,0", busy, mac_clr);
        else pass_cnt++;
        pulse_start(17);
        n = 0;
        wait_valid(n);
        chk_cnt++;
        if (n !== 18 || rif.res !== 64'd16)
            $display("FAIL len17_clamp: latency=%0d res=%0d want 18,16", n, rif.res);
        else pass_cnt++;
        accept_result();
`endif
    endtask

    initial begin
        rif.res_ready = 1'b0;
        test_reset();
        test_basic();
        test_busy_protect();
        test_reset_mid_run();
        test_single();
        test_back_to_back();
        test_len_bounds();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
